// File: rtl/pc_fetch.sv
// pc_fetch: PC register and instruction-fetch sequencer for the rvseed core.
// Holds the architectural PC. It fetches the word at that PC over a req/gnt +
// rvalid handshake, then presents the word downstream with valid/ready. The
// next-PC mux result is loaded only when downstream accepts the instruction.
module pc_fetch #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000,
    parameter int                   TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CPU_WIDTH-1:0] i_next_pc,
    output logic [CPU_WIDTH-1:0] o_curr_pc,
    output logic                 o_pc_ena,
    output logic                 o_imem_req,
    output logic [CPU_WIDTH-1:0] o_imem_addr,
    input  logic                 i_imem_gnt,
    input  logic                 i_imem_rvalid,
    input  logic [CPU_WIDTH-1:0] i_imem_rdata,
    input  logic                 i_imem_err,
    output logic [CPU_WIDTH-1:0] o_inst,
    output logic [CPU_WIDTH-1:0] o_inst_pc,
    output logic                 o_inst_valid,
    input  logic                 i_inst_ready,
    output logic                 o_fetch_fault,
    output logic [CPU_WIDTH-1:0] o_fault_addr,
    output logic [31:0]          o_fetch_cnt
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RSP,
        S_DELIVER,
        S_FAULT
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [CPU_WIDTH-1:0] r_curr_pc;
    logic [CPU_WIDTH-1:0] r_inst;
    logic [CPU_WIDTH-1:0] r_inst_pc;
    logic [CPU_WIDTH-1:0] r_fault_addr;
    logic [31:0]          r_fetch_cnt;
    logic [CNT_W-1:0]     r_timeout_cnt;

    logic                 w_aligned;
    logic                 w_deliver;
    logic                 w_commit;
    logic                 w_rsp_ok;
    logic                 w_timed_out;
    logic                 w_enter_fault;

    // A PC that is not word-aligned can never be fetched and faults in REQ.
    assign w_aligned     = (r_curr_pc[1:0] == 2'b00);
    assign w_deliver     = (r_state == S_DELIVER);
    assign w_commit      = w_deliver && i_inst_ready;
    assign w_rsp_ok      = (r_state == S_WAIT_RSP) && i_imem_rvalid && !i_imem_err;
    assign w_timed_out   = (r_state == S_WAIT_RSP) && !i_imem_rvalid
                           && (r_timeout_cnt == CNT_LAST);
    assign w_enter_fault = (w_next_state == S_FAULT) && (r_state != S_FAULT);

    // The request is a decode of registered state and PC, never of imem inputs.
    assign o_imem_req    = (r_state == S_REQ) && w_aligned;
    assign o_imem_addr   = r_curr_pc;
    assign o_curr_pc     = r_curr_pc;
    assign o_inst_valid  = w_deliver;
    assign o_pc_ena      = w_commit;
    assign o_inst        = r_inst;
    assign o_inst_pc     = r_inst_pc;
    assign o_fetch_fault = (r_state == S_FAULT);
    assign o_fault_addr  = r_fault_addr;
    assign o_fetch_cnt   = r_fetch_cnt;

    // Next-state decode for the fetch sequence; FAULT is left only by reset.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: w_next_state = S_REQ;
            S_REQ: begin
                if (!w_aligned) begin
                    w_next_state = S_FAULT;
                end else if (i_imem_gnt) begin
                    w_next_state = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (i_imem_rvalid) begin
                    w_next_state = i_imem_err ? S_FAULT : S_DELIVER;
                end else if (w_timed_out) begin
                    w_next_state = S_FAULT;
                end
            end
            S_DELIVER: begin
                if (i_inst_ready) begin
                    w_next_state = S_REQ;
                end
            end
            S_FAULT: w_next_state = S_FAULT;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register; reset parks in IDLE so no request goes out on the first cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // PC and commit counter advance only when downstream accepts the instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_curr_pc   <= RESET_PC;
            r_fetch_cnt <= 32'd0;
        end else if (w_commit) begin
            r_curr_pc   <= i_next_pc;
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    // Response watchdog: cleared while requesting, counts cycles waiting without rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout_cnt <= '0;
        end else if (r_state == S_REQ) begin
            r_timeout_cnt <= '0;
        end else if ((r_state == S_WAIT_RSP) && !i_imem_rvalid && (r_timeout_cnt != CNT_LAST)) begin
            r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
        end
    end

    // Capture the returned word and its PC; held stable through any downstream stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst    <= '0;
            r_inst_pc <= '0;
        end else if (w_rsp_ok) begin
            r_inst    <= i_imem_rdata;
            r_inst_pc <= r_curr_pc;
        end
    end

    // Record the PC responsible for the fault on the way into FAULT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault_addr <= '0;
        end else if (w_enter_fault) begin
            r_fault_addr <= r_curr_pc;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed and randomized fetch traffic against pc_fetch, with
// a transaction-level reference of the fetch sequence kept in the bench.
module tb_pc_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          TIMEOUT  = 8;

    logic        clk;
    logic        rstN;
    logic [31:0] nextPc;
    logic [31:0] currPc;
    logic        pcEna;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic        imemErr;
    logic [31:0] inst;
    logic [31:0] instPc;
    logic        instValid;
    logic        instReady;
    logic        fetchFault;
    logic [31:0] faultAddr;
    logic [31:0] fetchCnt;

    int vectors     = 0;
    int miscompares = 0;

    pc_fetch #(
        .CPU_WIDTH (32),
        .RESET_PC  (RESET_PC),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rstN),
        .i_next_pc     (nextPc),
        .o_curr_pc     (currPc),
        .o_pc_ena      (pcEna),
        .o_imem_req    (imemReq),
        .o_imem_addr   (imemAddr),
        .i_imem_gnt    (imemGnt),
        .i_imem_rvalid (imemRvalid),
        .i_imem_rdata  (imemRdata),
        .i_imem_err    (imemErr),
        .o_inst        (inst),
        .o_inst_pc     (instPc),
        .o_inst_valid  (instValid),
        .i_inst_ready  (instReady),
        .o_fetch_fault (fetchFault),
        .o_fault_addr  (faultAddr),
        .o_fetch_cnt   (fetchCnt)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference view of the fetcher as a set of facts about the transaction in flight.
    bit          mFresh;
    bit          mFaulted;
    bit          mHolding;
    bit          mAwaiting;
    int          mWaitCycles;
    logic [31:0] mPc;
    logic [31:0] mCount;
    logic [31:0] mInst;
    logic [31:0] mInstPc;
    logic [31:0] mFaultAddr;

    function automatic bit inReqPhase();
        return !mFresh && !mFaulted && !mHolding && !mAwaiting;
    endfunction

    // Advance the reference on each accepted clock, or drop everything on reset.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mFresh      <= 1'b1;
            mFaulted    <= 1'b0;
            mHolding    <= 1'b0;
            mAwaiting   <= 1'b0;
            mWaitCycles <= 0;
            mPc         <= RESET_PC;
            mCount      <= 32'd0;
            mInst       <= 32'd0;
            mInstPc     <= 32'd0;
            mFaultAddr  <= 32'd0;
        end else if (mFresh) begin
            mFresh <= 1'b0;
        end else if (mFaulted) begin
            mFaulted <= 1'b1;
        end else if (mHolding) begin
            if (instReady) begin
                mPc      <= nextPc;
                mCount   <= mCount + 32'd1;
                mHolding <= 1'b0;
            end
        end else if (mAwaiting) begin
            if (imemRvalid) begin
                mAwaiting <= 1'b0;
                if (imemErr) begin
                    mFaulted   <= 1'b1;
                    mFaultAddr <= mPc;
                end else begin
                    mHolding <= 1'b1;
                    mInst    <= imemRdata;
                    mInstPc  <= mPc;
                end
            end else if (mWaitCycles + 1 == TIMEOUT) begin
                mAwaiting  <= 1'b0;
                mFaulted   <= 1'b1;
                mFaultAddr <= mPc;
            end else begin
                mWaitCycles <= mWaitCycles + 1;
            end
        end else begin
            if (mPc % 4 != 0) begin
                mFaulted   <= 1'b1;
                mFaultAddr <= mPc;
            end else if (imemGnt) begin
                mAwaiting   <= 1'b1;
                mWaitCycles <= 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle, away from the rising edge, the DUT must agree with the reference.
    always @(negedge clk) begin
        checkOutput("curr_pc",     currPc,            mPc);
        checkOutput("imem_addr",   imemAddr,          mPc);
        checkOutput("imem_req",    32'(imemReq),      32'(inReqPhase() && (mPc % 4 == 0)));
        checkOutput("inst_valid",  32'(instValid),    32'(mHolding && !mFaulted));
        checkOutput("pc_ena",      32'(pcEna),        32'(mHolding && !mFaulted && instReady));
        checkOutput("inst",        inst,              mInst);
        checkOutput("inst_pc",     instPc,            mInstPc);
        checkOutput("fetch_fault", 32'(fetchFault),   32'(mFaulted));
        checkOutput("fault_addr",  faultAddr,         mFaultAddr);
        checkOutput("fetch_cnt",   fetchCnt,          mCount);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idleInputs();
        imemGnt    = 1'b0;
        imemRvalid = 1'b0;
        imemErr    = 1'b0;
        imemRdata  = 32'd0;
        instReady  = 1'b0;
    endtask

    // Reset asserted mid-cycle, released just after the following rising edge.
    task automatic pulseReset();
        #2;
        rstN = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    // From REQ: grant, wait 'latency' empty cycles, return 'word'; ends in DELIVER.
    task automatic fetchOne(input logic [31:0] word, input int latency);
        imemGnt = 1'b1;
        step();
        imemGnt = 1'b0;
        repeat (latency) step();
        imemRvalid = 1'b1;
        imemRdata  = word;
        step();
        imemRvalid = 1'b0;
    endtask

    // One cycle of legal random memory and downstream behaviour.
    task automatic applyStimulus();
        logic [31:0] tmp;
        idleInputs();
        tmp       = $urandom;
        imemRdata = $urandom;
        if (inReqPhase()) begin
            imemGnt    = ($urandom_range(0, 2) == 0);
            imemRvalid = !imemGnt && ($urandom_range(0, 9) == 0);
        end else if (mAwaiting) begin
            imemRvalid = ($urandom_range(0, 3) == 0);
            imemErr    = imemRvalid && ($urandom_range(0, 19) == 0);
        end else begin
            imemRvalid = ($urandom_range(0, 9) == 0);
        end
        instReady = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 29) == 0) begin
            nextPc = tmp;
        end else begin
            nextPc = tmp & 32'hFFFF_FFFC;
        end
    endtask

    initial begin
        logic [31:0] word;
        int          faultCycles;

        rstN   = 1'b0;
        nextPc = 32'd0;
        idleInputs();
        repeat (3) step();

        // First fetch after reset release
        rstN = 1'b1;
        settle();
        checkOutput("lit_req_cycle1", 32'(imemReq), 32'd0);
        step();
        checkOutput("lit_req_cycle2", 32'(imemReq), 32'd1);
        checkOutput("lit_first_addr", imemAddr, 32'h8000_0000);
        fetchOne(32'h0000_0013, 0);
        checkOutput("lit_valid_first", 32'(instValid), 32'd1);
        checkOutput("lit_inst_first", inst, 32'h0000_0013);
        checkOutput("lit_instpc_first", instPc, 32'h8000_0000);
        instReady = 1'b1;
        nextPc    = 32'h8000_0004;
        settle();
        checkOutput("lit_pcena_first", 32'(pcEna), 32'd1);
        step();
        instReady = 1'b0;
        checkOutput("lit_pc_after_commit", currPc, 32'h8000_0004);
        checkOutput("lit_cnt_after_commit", fetchCnt, 32'd1);
        checkOutput("lit_req_after_commit", 32'(imemReq), 32'd1);

        // Downstream stall with next_pc wandering
        word = $urandom;
        fetchOne(word, 0);
        for (int i = 0; i < 10; i++) begin
            nextPc = $urandom;
            settle();
            checkOutput("lit_stall_pcena", 32'(pcEna), 32'd0);
            checkOutput("lit_stall_inst", inst, word);
            checkOutput("lit_stall_instpc", instPc, 32'h8000_0004);
            checkOutput("lit_stall_pc", currPc, 32'h8000_0004);
            step();
        end
        instReady = 1'b1;
        nextPc    = 32'h8000_0100;
        settle();
        checkOutput("lit_release_pcena", 32'(pcEna), 32'd1);
        step();
        instReady = 1'b0;
        checkOutput("lit_release_cnt", fetchCnt, 32'd2);
        checkOutput("lit_release_valid", 32'(instValid), 32'd0);

        // Jump target, then a misaligned target
        checkOutput("lit_jump_addr", imemAddr, 32'h8000_0100);
        checkOutput("lit_jump_req", 32'(imemReq), 32'd1);
        fetchOne($urandom, 2);
        instReady = 1'b1;
        nextPc    = 32'h8000_0102;
        step();
        instReady = 1'b0;
        checkOutput("lit_misalign_req", 32'(imemReq), 32'd0);
        step();
        checkOutput("lit_misalign_fault", 32'(fetchFault), 32'd1);
        checkOutput("lit_misalign_addr", faultAddr, 32'h8000_0102);
        instReady = 1'b1;
        nextPc    = 32'd0;
        repeat (3) step();
        checkOutput("lit_fault_pc_frozen", currPc, 32'h8000_0102);
        checkOutput("lit_fault_pcena", 32'(pcEna), 32'd0);
        checkOutput("lit_fault_cnt", fetchCnt, 32'd3);
        instReady = 1'b0;

        // Grant held off for 5 cycles, spurious rvalid while requesting
        pulseReset();
        step();
        for (int i = 0; i < 5; i++) begin
            imemRvalid = (i == 2);
            checkOutput("lit_hold_req", 32'(imemReq), 32'd1);
            checkOutput("lit_hold_addr", imemAddr, 32'h8000_0000);
            step();
        end
        imemRvalid = 1'b0;
        checkOutput("lit_spurious_valid", 32'(instValid), 32'd0);
        fetchOne($urandom, 1);
        instReady = 1'b1;
        nextPc    = 32'h8000_0008;
        step();
        instReady = 1'b0;

        // Bus error on the response
        checkOutput("lit_err_addr_req", imemAddr, 32'h8000_0008);
        imemGnt = 1'b1;
        step();
        imemGnt    = 1'b0;
        imemRvalid = 1'b1;
        imemErr    = 1'b1;
        step();
        imemRvalid = 1'b0;
        imemErr    = 1'b0;
        checkOutput("lit_err_fault", 32'(fetchFault), 32'd1);
        checkOutput("lit_err_fault_addr", faultAddr, 32'h8000_0008);
        checkOutput("lit_err_valid", 32'(instValid), 32'd0);

        // Asynchronous reset while waiting for a response
        pulseReset();
        step();
        word = $urandom | 32'h1;
        fetchOne(word, 0);
        instReady = 1'b1;
        nextPc    = 32'h8000_0040;
        step();
        instReady = 1'b0;
        checkOutput("lit_pre_reset_cnt", fetchCnt, 32'd1);
        imemGnt = 1'b1;
        step();
        imemGnt = 1'b0;
        repeat (2) step();
        instReady = 1'b1;
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("lit_areset_pc", currPc, RESET_PC);
        checkOutput("lit_areset_cnt", fetchCnt, 32'd0);
        checkOutput("lit_areset_inst", inst, 32'd0);
        checkOutput("lit_areset_req", 32'(imemReq), 32'd0);
        checkOutput("lit_areset_pcena", 32'(pcEna), 32'd0);
        @(posedge clk);
        #1;
        rstN       = 1'b1;
        instReady  = 1'b0;
        imemRvalid = 1'b1;
        imemRdata  = $urandom;
        step();
        imemRvalid = 1'b0;
        checkOutput("lit_refetch_req", 32'(imemReq), 32'd1);
        checkOutput("lit_refetch_addr", imemAddr, RESET_PC);
        checkOutput("lit_refetch_valid", 32'(instValid), 32'd0);

        // Response never arrives
        imemGnt = 1'b1;
        step();
        imemGnt = 1'b0;
        repeat (TIMEOUT - 1) step();
        checkOutput("lit_timeout_early", 32'(fetchFault), 32'd0);
        step();
        checkOutput("lit_timeout_fault", 32'(fetchFault), 32'd1);
        checkOutput("lit_timeout_addr", faultAddr, RESET_PC);

        // Randomized traffic with periodic and random resets
        pulseReset();
        faultCycles = 0;
        for (int n = 0; n < 3000; n++) begin
            if (mFaulted) begin
                faultCycles++;
            end else begin
                faultCycles = 0;
            end
            if (faultCycles > 3 || $urandom_range(0, 299) == 0) begin
                pulseReset();
                faultCycles = 0;
            end else begin
                applyStimulus();
                step();
            end
        end

        idleInputs();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- PC register and instruction-fetch sequencer for the rvseed core.
- Holds the architectural current PC, which feeds the next-PC mux.
- Fetches the word at that PC from instruction memory over a req/gnt + rvalid handshake, then presents it downstream with valid/ready.
- Loads the next-PC mux result only when the downstream stage accepts the instruction.

Parameters:
CPU_WIDTH, 32, data/address width (matches `CPU_WIDTH)
RESET_PC, 32'h8000_0000, PC value loaded at reset
TIMEOUT, 64, max cycles to wait in WAIT_RSP for rvalid before faulting (>=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
next_pc  in  CPU_WIDTH  next PC from the next-PC mux
curr_pc  out  CPU_WIDTH  current PC register; drives next-PC mux and imem_addr
pc_ena  out  1  enable to next-PC mux; high only on the commit cycle
imem_req  out  1  fetch request
imem_addr  out  CPU_WIDTH  fetch address, equals curr_pc
imem_gnt  in  1  request accepted
imem_rvalid  in  1  read data valid
imem_rdata  in  CPU_WIDTH  instruction word
imem_err  in  1  bus error, qualified by imem_rvalid
inst  out  CPU_WIDTH  fetched instruction
inst_pc  out  CPU_WIDTH  PC of inst
inst_valid  out  1  inst/inst_pc valid
inst_ready  in  1  downstream accepts (commit)
fetch_fault  out  1  sticky fault flag
fault_addr  out  CPU_WIDTH  PC that faulted
fetch_cnt  out  32  count of committed instructions

Behaviour:
- Reset (rst_n low, async): state=IDLE, curr_pc=RESET_PC, inst=0, inst_pc=0, fetch_fault=0, fault_addr=0, fetch_cnt=0, timeout counter=0. imem_req=0, inst_valid=0, pc_ena=0. Reset mid-transaction abandons it; any later rvalid is ignored.
- States: IDLE, REQ, WAIT_RSP, DELIVER, FAULT. All outputs decode from registered state; no combinational path from imem inputs to imem_req.
- IDLE: go to REQ on the next clock. Guarantees no request in the first cycle after reset release.
- REQ:
  - If curr_pc[1:0]!=0: imem_req=0; next state FAULT; fault_addr<=curr_pc.
  - Otherwise imem_req=1 and imem_addr=curr_pc, both stable until gnt.
  - imem_gnt=1 -> WAIT_RSP, timeout counter cleared.
  - imem_rvalid in REQ is ignored.
- WAIT_RSP:
  - imem_req=0. The counter increments each cycle without rvalid.
  - rvalid & ~err: inst<=imem_rdata, inst_pc<=curr_pc; next state DELIVER.
  - rvalid & err: fault_addr<=curr_pc; next state FAULT.
  - Counter reaching TIMEOUT-1 without rvalid: fault_addr<=curr_pc; next state FAULT.
  - rvalid on the same cycle as gnt is not legal; memory returns at least 1 cycle after gnt.
- DELIVER:
  - inst_valid=1; inst/inst_pc held stable while inst_ready=0, with no limit on stall length.
  - pc_ena = inst_valid & inst_ready. On that cycle: curr_pc<=next_pc, fetch_cnt<=fetch_cnt+1 (wraps mod 2^32), next state REQ.
  - Commit-to-next-request gap is exactly 1 cycle.
- FAULT: terminal until reset. fetch_fault=1, inst_valid=0, imem_req=0, pc_ena=0, curr_pc frozen.
- Throughput: at most one instruction per 3 cycles at zero memory latency (REQ, WAIT_RSP, DELIVER). No speculation, so no flush is needed.
- next_pc is sampled only when pc_ena=1; its value at other times is don't-care.
- The next-PC mux itself holds next_pc=curr_pc when its enable is low; this block does not rely on that.

Test Plan:
- Reset release, gnt in REQ, rvalid 1 cycle later with rdata=32'h00000013, inst_ready=1, next_pc=32'h8000_0004:
  - imem_req first high in cycle 2 after release, addr 32'h8000_0000.
  - inst_valid 1 cycle later; pc_ena pulses.
  - curr_pc becomes 32'h8000_0004; fetch_cnt=1.
- Downstream stall: inst_ready=0 for 10 cycles with next_pc toggling:
  - inst, inst_pc and curr_pc are stable; pc_ena=0.
  - On release, exactly one commit.
- Jump commit with next_pc=32'h8000_0100:
  - Next imem_addr is 32'h8000_0100.
  - Then with next_pc=32'h8000_0102, the following REQ cycle produces no request; fetch_fault=1, fault_addr=32'h8000_0102.
- gnt delayed 5 cycles:
  - imem_req/addr held for all 5 cycles.
  - A spurious rvalid during REQ is ignored.
- rvalid with imem_err=1 at PC 32'h8000_0008: FAULT; fault_addr=32'h8000_0008; inst_valid stays 0.
- With TIMEOUT=8 and no rvalid:
  - FAULT entered 8 cycles after gnt.
  - Async rst_n pulse mid-WAIT_RSP: all outputs return to reset values immediately, and refetch starts from RESET_PC.
